friscv_mem_arbiter: RTL and testbench

//  Shares one external single-port memory between instruction fetch (IF) and

---
 rtl/friscv_sv_pkg.sv | 24 ++
 rtl/friscv_mem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_friscv_mem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/friscv_sv_pkg.sv
// -----------------------------------------------------------------------------
// friscv_sv_pkg
//   Shared types for the friscv core. This slice holds the memory arbiter
//   types:
//     arb_state_t : arbiter FSM state (idle / transaction outstanding)
//     arb_src_t   : requester that owns the outstanding transaction
//   Ports: none (package).
// -----------------------------------------------------------------------------
package friscv_sv_pkg;

   // Default architectural data/address width.
   localparam int ARCH_DEFAULT = 32;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   typedef enum logic {
      SRC_IF = 1'b0,
      SRC_D  = 1'b1
   } arb_src_t;

endpackage : friscv_sv_pkg

// File: rtl/friscv_mem_arbiter.sv
// -----------------------------------------------------------------------------
// friscv_mem_arbiter
//   Shares one external single-port memory between instruction fetch (IF) and
//   data access (D). One transaction is outstanding at a time. D has fixed
//   priority, but after MAX_D_STREAK consecutive D grants with IF waiting, IF
//   wins the next arbitration.
//
//   Timing: a grant happens only in IDLE and drives the memory strobe in the
//   same cycle. The owner's rvalid pulses MEM_LAT cycles later, in the cycle the
//   FSM returns to IDLE, so the next grant is at the earliest MEM_LAT+1 cycles
//   after the previous one.
//
//   Ports:
//     clk, rst_n                     clock, async active-low reset
//     if_req_in / if_addr_in         IF request, held until if_gnt_out
//     if_gnt_out                     IF accepted (pulse)
//     if_rvalid_out / if_rdata_out   IF read data (pulse)
//     d_req_in / d_we_in /
//     d_addr_in / d_wdata_in         D request, held until d_gnt_out
//     d_gnt_out                      D accepted (pulse)
//     d_rvalid_out / d_rdata_out     D completion; rdata is 0 for writes
//     mem_req_out / mem_we_out /
//     mem_addr_out / mem_wdata_out   memory strobe, grant cycle only
//     mem_rdata_in                   memory read data, MEM_LAT after strobe
// -----------------------------------------------------------------------------
module friscv_mem_arbiter
   import friscv_sv_pkg::*;
#(
   parameter int ARCH         = ARCH_DEFAULT,
   parameter int MEM_LAT      = 1,
   parameter int MAX_D_STREAK = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            if_req_in,
   input  logic [ARCH-1:0] if_addr_in,
   output logic            if_gnt_out,
   output logic            if_rvalid_out,
   output logic [ARCH-1:0] if_rdata_out,
   input  logic            d_req_in,
   input  logic            d_we_in,
   input  logic [ARCH-1:0] d_addr_in,
   input  logic [ARCH-1:0] d_wdata_in,
   output logic            d_gnt_out,
   output logic            d_rvalid_out,
   output logic [ARCH-1:0] d_rdata_out,
   output logic            mem_req_out,
   output logic            mem_we_out,
   output logic [ARCH-1:0] mem_addr_out,
   output logic [ARCH-1:0] mem_wdata_out,
   input  logic [ARCH-1:0] mem_rdata_in
);

   localparam int LAT_W    = $clog2(MEM_LAT + 1);
   localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);

   localparam logic [LAT_W-1:0]    LAT_MAX    = LAT_W'(MEM_LAT);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

   // Elaboration-time parameter checks.
   if (MEM_LAT < 1) begin : g_bad_mem_lat
      $error("friscv_mem_arbiter: MEM_LAT must be >= 1");
   end
   if (MAX_D_STREAK < 1) begin : g_bad_max_d_streak
      $error("friscv_mem_arbiter: MAX_D_STREAK must be >= 1");
   end

   arb_state_t           state_q,   state_d;
   logic [LAT_W-1:0]     lat_cnt_q, lat_cnt_d;
   logic [STREAK_W-1:0]  streak_q,  streak_d;
   arb_src_t             owner_q,   owner_d;
   logic                 wr_q,      wr_d;

   logic gnt_if;
   logic gnt_d;
   logic done;

   // Arbitration. Grants are combinational on the requests, so they are
   // gated with rst_n to keep every output at 0 while reset is held.
   always_comb begin
      // NOTE: every signal written here gets a default first; a path that
      // leaves one unassigned would infer a latch.
      gnt_if = 1'b0;
      gnt_d  = 1'b0;
      if (rst_n && (state_q == ARB_IDLE)) begin
         if (if_req_in && d_req_in) begin
            if (streak_q == STREAK_MAX) begin
               gnt_if = 1'b1;
            end else begin
               gnt_d  = 1'b1;
            end
         end else begin
            gnt_if = if_req_in;
            gnt_d  = d_req_in;
         end
      end
   end

   assign done = (state_q == ARB_BUSY) && (lat_cnt_q == LAT_MAX);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ARB_IDLE;
         lat_cnt_q <= '0;
         streak_q  <= '0;
         owner_q   <= SRC_IF;
         wr_q      <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values of the others.
         state_q   <= state_d;
         lat_cnt_q <= lat_cnt_d;
         streak_q  <= streak_d;
         owner_q   <= owner_d;
         wr_q      <= wr_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d   = state_q;
      lat_cnt_d = lat_cnt_q;
      owner_d   = owner_q;
      wr_d      = wr_q;
      streak_d  = streak_q;

      unique case (state_q)
         ARB_IDLE: begin
            if (gnt_if || gnt_d) begin
               state_d   = ARB_BUSY;
               lat_cnt_d = LAT_W'(1);
               owner_d   = gnt_d ? SRC_D : SRC_IF;
               wr_d      = gnt_d && d_we_in;
            end
         end
         ARB_BUSY: begin
            if (done) begin
               state_d   = ARB_IDLE;
               lat_cnt_d = '0;
            end else begin
               lat_cnt_d = lat_cnt_q + LAT_W'(1);
            end
         end
         default: state_d = ARB_IDLE;
      endcase

      // Streak counts D wins while IF is actually waiting; it saturates at
      // the limit so the IF override stays armed until IF is served.
      if (!if_req_in || gnt_if) begin
         streak_d = '0;
      end else if (gnt_d && (streak_q != STREAK_MAX)) begin
         streak_d = streak_q + STREAK_W'(1);
      end
   end

   // Output logic.
   always_comb begin
      if_gnt_out    = gnt_if;
      d_gnt_out     = gnt_d;
      mem_req_out   = gnt_if || gnt_d;
      mem_we_out    = 1'b0;
      mem_addr_out  = '0;
      mem_wdata_out = '0;
      if_rvalid_out = 1'b0;
      if_rdata_out  = '0;
      d_rvalid_out  = 1'b0;
      d_rdata_out   = '0;

      if (gnt_d) begin
         mem_we_out    = d_we_in;
         mem_addr_out  = d_addr_in;
         mem_wdata_out = d_wdata_in;
      end else if (gnt_if) begin
         mem_addr_out  = if_addr_in;
      end

      if (done) begin
         if (owner_q == SRC_D) begin
            d_rvalid_out = 1'b1;
            d_rdata_out  = wr_q ? '0 : mem_rdata_in;
         end else begin
            if_rvalid_out = 1'b1;
            if_rdata_out  = mem_rdata_in;
         end
      end
   end

endmodule : friscv_mem_arbiter

// File: tb/tb_friscv_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_friscv_mem_arbiter
//   Two arbiter instances: index 0 with MEM_LAT=1/MAX_D_STREAK=4, index 1 with
//   MEM_LAT=3/MAX_D_STREAK=2. Directed vector table, a grant-order sequence,
//   then random traffic against a cycle-count based reference model.
// -----------------------------------------------------------------------------
module tb_friscv_mem_arbiter;

   localparam int W = 32;
   localparam int LAT0 = 1, MAX0 = 4;
   localparam int LAT1 = 3, MAX1 = 2;
   localparam logic [W-1:0] NOISE = 32'hFFFF_0000;

   typedef struct packed {
      logic         if_req;
      logic [W-1:0] if_addr;
      logic         d_req;
      logic         d_we;
      logic [W-1:0] d_addr;
      logic [W-1:0] d_wdata;
      logic [W-1:0] mem_rdata;
   } in_t;

   typedef struct packed {
      logic         if_gnt;
      logic         if_rvalid;
      logic [W-1:0] if_rdata;
      logic         d_gnt;
      logic         d_rvalid;
      logic [W-1:0] d_rdata;
      logic         mem_req;
      logic         mem_we;
      logic [W-1:0] mem_addr;
      logic [W-1:0] mem_wdata;
   } out_t;

   typedef struct {
      int   inst;
      logic rst;
      in_t  in;
      out_t exp;
   } vec_t;

   logic       clk = 1'b0;
   logic [1:0] rst_n;
   in_t        din  [2];
   out_t       dout [2];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   friscv_mem_arbiter #(.ARCH(W), .MEM_LAT(LAT0), .MAX_D_STREAK(MAX0)) u_dut0 (
      .clk(clk), .rst_n(rst_n[0]),
      .if_req_in(din[0].if_req), .if_addr_in(din[0].if_addr),
      .if_gnt_out(dout[0].if_gnt), .if_rvalid_out(dout[0].if_rvalid),
      .if_rdata_out(dout[0].if_rdata),
      .d_req_in(din[0].d_req), .d_we_in(din[0].d_we),
      .d_addr_in(din[0].d_addr), .d_wdata_in(din[0].d_wdata),
      .d_gnt_out(dout[0].d_gnt), .d_rvalid_out(dout[0].d_rvalid),
      .d_rdata_out(dout[0].d_rdata),
      .mem_req_out(dout[0].mem_req), .mem_we_out(dout[0].mem_we),
      .mem_addr_out(dout[0].mem_addr), .mem_wdata_out(dout[0].mem_wdata),
      .mem_rdata_in(din[0].mem_rdata)
   );

   friscv_mem_arbiter #(.ARCH(W), .MEM_LAT(LAT1), .MAX_D_STREAK(MAX1)) u_dut1 (
      .clk(clk), .rst_n(rst_n[1]),
      .if_req_in(din[1].if_req), .if_addr_in(din[1].if_addr),
      .if_gnt_out(dout[1].if_gnt), .if_rvalid_out(dout[1].if_rvalid),
      .if_rdata_out(dout[1].if_rdata),
      .d_req_in(din[1].d_req), .d_we_in(din[1].d_we),
      .d_addr_in(din[1].d_addr), .d_wdata_in(din[1].d_wdata),
      .d_gnt_out(dout[1].d_gnt), .d_rvalid_out(dout[1].d_rvalid),
      .d_rdata_out(dout[1].d_rdata),
      .mem_req_out(dout[1].mem_req), .mem_we_out(dout[1].mem_we),
      .mem_addr_out(dout[1].mem_addr), .mem_wdata_out(dout[1].mem_wdata),
      .mem_rdata_in(din[1].mem_rdata)
   );

   // ---------------------------------------------------------------- checks
   task automatic check_out(input string name, input out_t act, input out_t exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // --------------------------------------------------------------- helpers
   function automatic in_t mk_in(input logic ir, input logic [W-1:0] ia,
                                 input logic dr, input logic we,
                                 input logic [W-1:0] da, input logic [W-1:0] dw,
                                 input logic [W-1:0] mr);
      in_t r;
      r.if_req = ir; r.if_addr = ia; r.d_req = dr; r.d_we = we;
      r.d_addr = da; r.d_wdata = dw; r.mem_rdata = mr;
      return r;
   endfunction

   function automatic out_t mk_out(input logic ig, input logic iv, input logic [W-1:0] ird,
                                   input logic dg, input logic dv, input logic [W-1:0] drd,
                                   input logic mq, input logic mw,
                                   input logic [W-1:0] ma, input logic [W-1:0] mwd);
      out_t r;
      r.if_gnt = ig; r.if_rvalid = iv; r.if_rdata = ird;
      r.d_gnt = dg; r.d_rvalid = dv; r.d_rdata = drd;
      r.mem_req = mq; r.mem_we = mw; r.mem_addr = ma; r.mem_wdata = mwd;
      return r;
   endfunction

   function automatic in_t idle_in(input logic [W-1:0] mr);
      return mk_in(1'b0, '0, 1'b0, 1'b0, '0, '0, mr);
   endfunction

   function automatic int lat_of(input int k);
      return (k == 0) ? LAT0 : LAT1;
   endfunction

   function automatic int max_of(input int k);
      return (k == 0) ? MAX0 : MAX1;
   endfunction

   vec_t tbl[$];

   task automatic add(input int inst, input logic rst, input in_t i, input out_t o);
      vec_t v;
      v.inst = inst; v.rst = rst; v.in = i; v.exp = o;
      tbl.push_back(v);
   endtask

   // ------------------------------------------------------- reference model
   // Tracks the absolute cycle at which the outstanding transaction completes
   // and the number of D wins in a row while IF keeps requesting.
   int m_cyc     [2];
   int m_done_at [2];
   int m_drun    [2];
   bit m_own_d   [2];
   bit m_wr      [2];

   task automatic model_reset(input int k);
      m_cyc[k] = 0; m_done_at[k] = -1; m_drun[k] = 0;
      m_own_d[k] = 1'b0; m_wr[k] = 1'b0;
   endtask

   // g: 0 no grant, 1 IF grant, 2 D grant
   task automatic model_eval(input int k, input in_t x, output out_t e, output int g);
      e = '0;
      g = 0;
      if (m_done_at[k] == m_cyc[k]) begin
         if (m_own_d[k]) begin
            e.d_rvalid = 1'b1;
            e.d_rdata  = m_wr[k] ? '0 : x.mem_rdata;
         end else begin
            e.if_rvalid = 1'b1;
            e.if_rdata  = x.mem_rdata;
         end
      end else if (m_done_at[k] < 0) begin
         if (x.d_req && !(x.if_req && m_drun[k] >= max_of(k))) g = 2;
         else if (x.if_req) g = 1;
      end
      if (g == 1) begin
         e.if_gnt = 1'b1; e.mem_req = 1'b1; e.mem_addr = x.if_addr;
      end else if (g == 2) begin
         e.d_gnt = 1'b1; e.mem_req = 1'b1; e.mem_we = x.d_we;
         e.mem_addr = x.d_addr; e.mem_wdata = x.d_wdata;
      end
   endtask

   task automatic model_commit(input int k, input in_t x, input int g);
      if (m_done_at[k] == m_cyc[k]) m_done_at[k] = -1;
      if (g != 0) begin
         m_done_at[k] = m_cyc[k] + lat_of(k);
         m_own_d[k]   = (g == 2);
         m_wr[k]      = (g == 2) && x.d_we;
      end
      if (!x.if_req || g == 1) m_drun[k] = 0;
      else if (g == 2 && m_drun[k] < max_of(k)) m_drun[k]++;
      m_cyc[k]++;
   endtask

   // -------------------------------------------------------------- watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ------------------------------------------------------------------ main
   initial begin
      in_t  x;
      out_t e;
      int   seen;
      int   g       [2];
      in_t  cur     [2];
      out_t exp_rel;

      // Reset with both requesters active: outputs must stay at 0.
      rst_n = 2'b00;
      x = mk_in(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h99, 32'h1234);
      din[0] = x;
      din[1] = x;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_out("reset_out_lat1", dout[0], '0);
      check_out("reset_out_lat3", dout[1], '0);

      // First grant in the first cycle after release; D wins.
      @(posedge clk); #1;
      rst_n = 2'b11;
      @(negedge clk);
      exp_rel = mk_out(0, 0, '0, 1, 0, '0, 1, 0, 32'h20, 32'h99);
      check_out("release_gnt_lat1", dout[0], exp_rel);
      check_out("release_gnt_lat3", dout[1], exp_rel);
      @(posedge clk); #1;
      din[0] = idle_in(NOISE);
      din[1] = idle_in(NOISE);
      repeat (5) @(posedge clk);

      // ---- directed vectors, instance 0 (MEM_LAT=1)
      add(0, 1, mk_in(1, 32'h10, 0, 0, '0, '0, NOISE),       mk_out(1, 0, '0, 0, 0, '0, 1, 0, 32'h10, '0));
      add(0, 1, idle_in(32'hDEAD_BEEF),                     mk_out(0, 1, 32'hDEAD_BEEF, 0, 0, '0, 0, 0, '0, '0));
      add(0, 1, mk_in(1, 32'h14, 0, 0, '0, '0, NOISE),       mk_out(1, 0, '0, 0, 0, '0, 1, 0, 32'h14, '0));
      add(0, 1, idle_in(32'h1234_5678),                     mk_out(0, 1, 32'h1234_5678, 0, 0, '0, 0, 0, '0, '0));
      add(0, 1, mk_in(0, '0, 1, 1, 32'h200, 32'h55, NOISE),  mk_out(0, 0, '0, 1, 0, '0, 1, 1, 32'h200, 32'h55));
      add(0, 1, idle_in(32'hAAAA_5555),                     mk_out(0, 0, '0, 0, 1, '0, 0, 0, '0, '0));
      add(0, 1, mk_in(0, '0, 1, 0, 32'h300, '0, NOISE),      mk_out(0, 0, '0, 1, 0, '0, 1, 0, 32'h300, '0));
      add(0, 1, idle_in(32'hCAFE_F00D),                     mk_out(0, 0, '0, 0, 1, 32'hCAFE_F00D, 0, 0, '0, '0));
      add(0, 1, mk_in(1, 32'h40, 1, 0, 32'h500, '0, NOISE),  mk_out(0, 0, '0, 1, 0, '0, 1, 0, 32'h500, '0));
      add(0, 1, mk_in(1, 32'h40, 0, 0, '0, '0, 32'h0BAD_F00D), mk_out(0, 0, '0, 0, 1, 32'h0BAD_F00D, 0, 0, '0, '0));
      add(0, 1, mk_in(1, 32'h40, 0, 0, '0, '0, NOISE),       mk_out(1, 0, '0, 0, 0, '0, 1, 0, 32'h40, '0));
      add(0, 1, idle_in(32'h7777_7777),                     mk_out(0, 1, 32'h7777_7777, 0, 0, '0, 0, 0, '0, '0));
      // ---- instance 1 (MEM_LAT=3): D raised during BUSY waits for IDLE
      add(1, 1, mk_in(1, 32'h40, 0, 0, '0, '0, NOISE),       mk_out(1, 0, '0, 0, 0, '0, 1, 0, 32'h40, '0));
      add(1, 1, mk_in(0, '0, 1, 0, 32'h80, '0, NOISE),       '0);
      add(1, 1, mk_in(0, '0, 1, 0, 32'h80, '0, NOISE),       '0);
      add(1, 1, mk_in(0, '0, 1, 0, 32'h80, '0, 32'h1111_1111), mk_out(0, 1, 32'h1111_1111, 0, 0, '0, 0, 0, '0, '0));
      add(1, 1, mk_in(0, '0, 1, 0, 32'h80, '0, NOISE),       mk_out(0, 0, '0, 1, 0, '0, 1, 0, 32'h80, '0));
      add(1, 1, idle_in(NOISE),                             '0);
      add(1, 1, idle_in(NOISE),                             '0);
      add(1, 1, idle_in(32'h2222_2222),                     mk_out(0, 0, '0, 0, 1, 32'h2222_2222, 0, 0, '0, '0));
      // ---- instance 1: reset at lat_cnt=1 drops the read for good
      add(1, 1, mk_in(1, 32'h60, 0, 0, '0, '0, NOISE),       mk_out(1, 0, '0, 0, 0, '0, 1, 0, 32'h60, '0));
      add(1, 0, idle_in(NOISE),                             '0);
      add(1, 0, mk_in(1, 32'h64, 0, 0, '0, '0, NOISE),       '0);
      add(1, 1, idle_in(NOISE),                             '0);
      add(1, 1, idle_in(32'h3333_3333),                     '0);
      add(1, 1, idle_in(32'h3333_3333),                     '0);
      add(1, 1, mk_in(1, 32'h64, 0, 0, '0, '0, NOISE),       mk_out(1, 0, '0, 0, 0, '0, 1, 0, 32'h64, '0));
      add(1, 1, idle_in(NOISE),                             '0);
      add(1, 1, idle_in(NOISE),                             '0);
      add(1, 1, idle_in(32'h4444_4444),                     mk_out(0, 1, 32'h4444_4444, 0, 0, '0, 0, 0, '0, '0));

      foreach (tbl[i]) begin
         @(posedge clk); #1;
         rst_n[tbl[i].inst] = tbl[i].rst;
         din[tbl[i].inst]   = tbl[i].in;
         @(negedge clk);
         check_out($sformatf("vec%0d_inst%0d", i, tbl[i].inst), dout[tbl[i].inst], tbl[i].exp);
      end

      // ---- grant order with both requesting continuously (instance 0)
      x = mk_in(1, 32'h100, 1, 0, 32'h200, '0, NOISE);
      seen = 0;
      for (int c = 0; c < 40 && seen < 10; c++) begin
         @(posedge clk); #1;
         din[0] = x;
         @(negedge clk);
         check_int($sformatf("gnt_rvalid_excl_c%0d", c),
                   int'((dout[0].if_gnt | dout[0].d_gnt) & (dout[0].if_rvalid | dout[0].d_rvalid)), 0);
         if (dout[0].if_gnt || dout[0].d_gnt) begin
            check_int($sformatf("order%0d", seen), int'({dout[0].if_gnt, dout[0].d_gnt}),
                      (seen % 5 == 4) ? 2 : 1);
            seen++;
         end
      end
      check_int("order_count", seen, 10);

      // ---- random traffic against the reference model
      @(posedge clk); #1;
      rst_n  = 2'b00;
      din[0] = idle_in('0);
      din[1] = idle_in('0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 2'b11;
      for (int k = 0; k < 2; k++) begin
         model_reset(k);
         cur[k] = idle_in('0);
         g[k]   = 0;
      end

      for (int c = 0; c < 800; c++) begin
         @(posedge clk); #1;
         for (int k = 0; k < 2; k++) begin
            x = cur[k];
            if (g[k] == 1) x.if_req = 1'b0;
            if (g[k] == 2) x.d_req  = 1'b0;
            if (!x.if_req) begin
               if ($urandom_range(0, 1) == 1) begin
                  x.if_req  = 1'b1;
                  x.if_addr = $urandom;
               end
            end else if ($urandom_range(0, 15) == 0) begin
               x.if_req = 1'b0;
            end
            if (!x.d_req) begin
               if ($urandom_range(0, 3) != 0) begin
                  x.d_req   = 1'b1;
                  x.d_we    = $urandom_range(0, 1) == 1;
                  x.d_addr  = $urandom;
                  x.d_wdata = $urandom;
               end
            end else if ($urandom_range(0, 15) == 0) begin
               x.d_req = 1'b0;
            end
            x.mem_rdata = $urandom;
            cur[k] = x;
            din[k] = x;
         end
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            model_eval(k, cur[k], e, g[k]);
            check_out($sformatf("rand_c%0d_inst%0d", c, k), dout[k], e);
            model_commit(k, cur[k], g[k]);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_friscv_mem_arbiter
